// File: rtl/pipe_pkg.sv
// Shared definitions for the PC generator: FSM states, instruction size and
// the byte-offset width of a fetch group.
package pipe_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pipe_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic int unsigned grp_off_w(input int unsigned fetch_w);
    return $clog2(fetch_w * INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pipe_pc_nextpc.sv
// Combinational next-PC selection: redirect priority, target alignment check
// and the valid-lane mask of the current fetch group.
module pipe_pc_nextpc
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FETCH_W = 2
) (
  input  logic [XLEN-1:0]    pc_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    flush_target_i,
  input  logic               br_taken_i,
  input  logic [XLEN-1:0]    br_target_i,
  output logic [XLEN-1:0]    next_pc_o,
  output logic               redirect_o,
  output logic               misalign_o,
  output logic [FETCH_W-1:0] mask_o
);

  localparam int unsigned     GRP_BYTES = FETCH_W * INSTR_BYTES;
  localparam logic [XLEN-1:0] GRP_MASK  = XLEN'(GRP_BYTES - 1);
  localparam logic [XLEN-1:0] GRP_STEP  = XLEN'(GRP_BYTES);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] first_lane;

  assign target     = flush_i ? flush_target_i : br_target_i;
  assign redirect_o = flush_i | br_taken_i;
  assign misalign_o = redirect_o && (target[1:0] != 2'b00);
  assign seq_pc     = (pc_i & ~GRP_MASK) + GRP_STEP;
  assign first_lane = (pc_i & GRP_MASK) >> 2;

  // A misaligned redirect leaves the PC where it is; the top halts on it.
  always_comb begin
    next_pc_o = seq_pc;
    if (redirect_o) begin
      next_pc_o = misalign_o ? pc_i : target;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end
  end

  always_comb begin
    mask_o = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      mask_o[k] = valid_i && (XLEN'(k) >= first_lane);
    end
  end

endmodule

// File: rtl/pipe_pc_gen.sv
// Fetch PC generator: WAIT/RUN/HALT control, fetch and ID registers, sticky
// misalign/timeout flags and a saturating run-cycle counter.
module pipe_pc_gen
  import pipe_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter int unsigned      FETCH_W    = 2,
  parameter logic [XLEN-1:0]  RESET_VEC  = 32'h0000_0000,
  parameter int unsigned      MAX_CYCLES = 12,
  localparam int unsigned     CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    flush_target_i,
  input  logic               br_taken_i,
  input  logic [XLEN-1:0]    br_target_i,
  output logic [XLEN-1:0]    fetch_pc_o,
  output logic               fetch_valid_o,
  output logic [FETCH_W-1:0] fetch_mask_o,
  output logic [XLEN-1:0]    id_pc_o,
  output logic               id_valid_o,
  output logic               misalign_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  pipe_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] nxt_pc;
  logic            nxt_redirect;
  logic            nxt_misalign;

  pipe_pc_nextpc #(
    .XLEN    (XLEN),
    .FETCH_W (FETCH_W)
  ) u_nextpc (
    .pc_i           (pc_q),
    .valid_i        (valid_q),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_target_i (flush_target_i),
    .br_taken_i     (br_taken_i),
    .br_target_i    (br_target_i),
    .next_pc_o      (nxt_pc),
    .redirect_o     (nxt_redirect),
    .misalign_o     (nxt_misalign),
    .mask_o         (fetch_mask_o)
  );

  // The halting edge itself freezes the PC, so HALT always shows the last
  // address that was actually fetched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    to_d       = to_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    unique case (state_q)
      WAIT: state_d = RUN;
      RUN: begin
        if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
        if (nxt_misalign) mis_d = 1'b1;
        if (cnt_d == MAX_CNT) to_d = 1'b1;
        if (nxt_misalign || (cnt_d == MAX_CNT)) state_d = HALT;
        else                                    pc_d    = nxt_pc;
      end
      default: ;
    endcase
    if (state_d == HALT) begin
      id_valid_d = 1'b0;
    end else if (nxt_redirect) begin
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      id_pc_d    = pc_q;
      id_valid_d = valid_q;
    end
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fetch_pc_o    = pc_q;
  assign fetch_valid_o = valid_q;
  assign id_pc_o       = id_pc_q;
  assign id_valid_o    = id_valid_q;
  assign misalign_o    = mis_q;
  assign timeout_o     = to_q;
  assign cycle_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_pc_gen.sv
// Scoreboard bench for pipe_pc_gen: a 2-wide instance for control behaviour and
// a 1-wide instance near the top of the address space for wrap-around.
module tb_pipe_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, stall, flush, br;
  logic [31:0] ft, bt;

  logic [31:0] pc1, idpc1;
  logic        v1, idv1, mis1, to1;
  logic [1:0]  m1;
  logic [3:0]  cnt1;

  logic [31:0] pc2, idpc2;
  logic        v2, idv2, mis2, to2;
  logic [0:0]  m2;
  logic [3:0]  cnt2;

  pipe_pc_gen #(
    .XLEN       (32),
    .FETCH_W    (2),
    .RESET_VEC  (32'h0000_0000),
    .MAX_CYCLES (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .flush_target_i (ft),
    .br_taken_i     (br),
    .br_target_i    (bt),
    .fetch_pc_o     (pc1),
    .fetch_valid_o  (v1),
    .fetch_mask_o   (m1),
    .id_pc_o        (idpc1),
    .id_valid_o     (idv1),
    .misalign_o     (mis1),
    .timeout_o      (to1),
    .cycle_cnt_o    (cnt1)
  );

  pipe_pc_gen #(
    .XLEN       (32),
    .FETCH_W    (1),
    .RESET_VEC  (32'hFFFF_FFFC),
    .MAX_CYCLES (12)
  ) dut_w1 (
    .clk            (clk),
    .rst            (rst2),
    .stall_i        (stall),
    .flush_i        (flush),
    .flush_target_i (ft),
    .br_taken_i     (br),
    .br_target_i    (bt),
    .fetch_pc_o     (pc2),
    .fetch_valid_o  (v2),
    .fetch_mask_o   (m2),
    .id_pc_o        (idpc2),
    .id_valid_o     (idv2),
    .misalign_o     (mis2),
    .timeout_o      (to2),
    .cycle_cnt_o    (cnt2)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic [1:0]  m;
    logic [31:0] idpc;
    logic        idv;
    logic        mis;
    logic        to;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t me;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, fld, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on the 2-wide instance and queue the outputs
  // expected just after the following rising edge.
  task automatic cyc(input string tag, input logic r, input logic s, input logic f,
                     input logic [31:0] fta, input logic b, input logic [31:0] bta,
                     input logic [31:0] pc, input logic v, input logic [1:0] m,
                     input logic [31:0] idpc, input logic idv, input logic mis,
                     input logic to, input logic [3:0] cnt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; ft = fta; br = b; bt = bta;
    e.tag = tag; e.pc = pc; e.v = v; e.m = m; e.idpc = idpc;
    e.idv = idv; e.mis = mis; e.to = to; e.cnt = cnt;
    q1.push_back(e);
  endtask

  task automatic cyc2(input string tag, input logic r,
                      input logic [31:0] pc, input logic v, input logic m);
    exp_t e;
    @(negedge clk);
    rst2 = r; stall = 1'b0; flush = 1'b0; br = 1'b0;
    e.tag = tag; e.pc = pc; e.v = v; e.m = {1'b0, m}; e.idpc = '0;
    e.idv = 1'b0; e.mis = 1'b0; e.to = 1'b0; e.cnt = '0;
    q2.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        me = q1.pop_front();
        chk(me.tag, "fetch_pc",    pc1,   me.pc);
        chk(me.tag, "fetch_valid", v1,    me.v);
        chk(me.tag, "fetch_mask",  m1,    me.m);
        chk(me.tag, "id_pc",       idpc1, me.idpc);
        chk(me.tag, "id_valid",    idv1,  me.idv);
        chk(me.tag, "misalign",    mis1,  me.mis);
        chk(me.tag, "timeout",     to1,   me.to);
        chk(me.tag, "cycle_cnt",   cnt1,  me.cnt);
      end
      if (q2.size() > 0) begin
        me = q2.pop_front();
        chk(me.tag, "fetch_pc",    pc2,          me.pc);
        chk(me.tag, "fetch_valid", v2,           me.v);
        chk(me.tag, "fetch_mask",  {31'b0, m2},  me.m);
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0;
    ft = '0; bt = '0;

    //   tag           r  s  f  ft       b  bt         pc        v  m      idpc      idv mis to cnt
    cyc("reset",       1, 0, 0, 0,       0, 0,         32'h0,    0, 2'b00, 32'h0,    0,  0,  0, 0);
    cyc("wait2run",    0, 0, 0, 0,       0, 0,         32'h0,    1, 2'b11, 32'h0,    0,  0,  0, 0);
    cyc("seq1",        0, 0, 0, 0,       0, 0,         32'h8,    1, 2'b11, 32'h0,    1,  0,  0, 1);
    cyc("seq2",        0, 0, 0, 0,       0, 0,         32'h10,   1, 2'b11, 32'h8,    1,  0,  0, 2);
    cyc("seq3",        0, 0, 0, 0,       0, 0,         32'h18,   1, 2'b11, 32'h10,   1,  0,  0, 3);
    cyc("br_stall",    0, 1, 0, 0,       1, 32'h104,   32'h104,  1, 2'b10, 32'h10,   0,  0,  0, 4);
    cyc("after_br",    0, 0, 0, 0,       0, 0,         32'h108,  1, 2'b11, 32'h104,  1,  0,  0, 5);
    cyc("stall",       0, 1, 0, 0,       0, 0,         32'h108,  1, 2'b11, 32'h104,  1,  0,  0, 6);
    cyc("resume",      0, 0, 0, 0,       0, 0,         32'h110,  1, 2'b11, 32'h108,  1,  0,  0, 7);
    cyc("flush_br",    0, 0, 1, 32'h200, 1, 32'h300,   32'h200,  1, 2'b11, 32'h108,  0,  0,  0, 8);
    cyc("after_flush", 0, 0, 0, 0,       0, 0,         32'h208,  1, 2'b11, 32'h200,  1,  0,  0, 9);
    cyc("misalign",    0, 0, 0, 0,       1, 32'h102,   32'h208,  0, 2'b00, 32'h200,  0,  1,  0, 10);
    cyc("halt_mis",    0, 0, 0, 0,       0, 0,         32'h208,  0, 2'b00, 32'h200,  0,  1,  0, 10);
    cyc("halt_ignore", 0, 1, 1, 32'h400, 1, 32'h500,   32'h208,  0, 2'b00, 32'h200,  0,  1,  0, 10);

    cyc("rst_in_halt", 1, 0, 0, 0,       0, 0,         32'h0,    0, 2'b00, 32'h0,    0,  0,  0, 0);
    cyc("wait2run_b",  0, 0, 0, 0,       0, 0,         32'h0,    1, 2'b11, 32'h0,    0,  0,  0, 0);
    for (int unsigned k = 1; k <= 11; k++) begin
      cyc("free_run",  0, 0, 0, 0,       0, 0,         8 * k,    1, 2'b11, 8 * (k - 1), 1, 0, 0, 4'(k));
    end
    cyc("timeout",     0, 0, 0, 0,       0, 0,         32'h58,   0, 2'b00, 32'h50,   0,  0,  1, 12);
    cyc("halt_to",     0, 0, 0, 0,       0, 0,         32'h58,   0, 2'b00, 32'h50,   0,  0,  1, 12);

    cyc("rst_c",       1, 0, 0, 0,       0, 0,         32'h0,    0, 2'b00, 32'h0,    0,  0,  0, 0);
    cyc("wait2run_c",  0, 0, 0, 0,       0, 0,         32'h0,    1, 2'b11, 32'h0,    0,  0,  0, 0);
    for (int unsigned k = 1; k <= 11; k++) begin
      cyc("run_c",     0, 0, 0, 0,       0, 0,         8 * k,    1, 2'b11, 8 * (k - 1), 1, 0, 0, 4'(k));
    end
    cyc("mis_and_to",  0, 0, 0, 0,       1, 32'h103,   32'h58,   0, 2'b00, 32'h50,   0,  1,  1, 12);
    cyc("halt_both",   0, 0, 0, 0,       0, 0,         32'h58,   0, 2'b00, 32'h50,   0,  1,  1, 12);
    cyc("rst_final",   1, 0, 0, 0,       0, 0,         32'h0,    0, 2'b00, 32'h0,    0,  0,  0, 0);

    cyc2("w1_reset",   1, 32'hFFFF_FFFC, 0, 1'b0);
    cyc2("w1_run",     0, 32'hFFFF_FFFC, 1, 1'b1);
    cyc2("w1_wrap",    0, 32'h0000_0000, 1, 1'b1);
    cyc2("w1_seq",     0, 32'h0000_0004, 1, 1'b1);

    for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (q1.size() > 0 || q2.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries still queued, expected 0", q1.size() + q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
